instr_mem_loader: RTL and testbench

//  Writes a program into the pipeline core's instruction memory (the writer side of the fetch-stage read port).

---
 rtl/instr_mem_loader_if.sv | 36 +++
 rtl/instr_mem_loader.sv | 187 ++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input, instruction-memory write port and load status for instr_mem_loader.
// The master drives the byte stream and start; the slave (the loader) drives everything else.
interface instr_mem_loader_if #(
    parameter int ADDR_W = 3
);
    // Load control and byte stream
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_byte;
    logic              in_last;

    // Instruction memory write port
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;

    // Core control and load status
    logic              core_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output start, in_valid, in_byte, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata,
        input  core_hold, busy, done, error, words_loaded
    );

    modport slave (
        input  start, in_valid, in_byte, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata,
        output core_hold, busy, done, error, words_loaded
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: packs a byte stream (high byte first) into 16-bit words,
// writes them into instruction memory and keeps the core held until a complete,
// even-length program that fits in memory has been written.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no load since reset, core held
//   HI     | waiting for the high byte of the next word
//   LO     | waiting for the low byte of the current word
//   WR     | single-cycle write of {hi, lo} to instruction memory
//   DONE   | program loaded, core released
//   ERR    | load aborted (odd byte count or overflow), core held
module instr_mem_loader #(
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic                clk,
    input  logic                reset_n,
    instr_mem_loader_if.slave   bus
);

    localparam int                WL_W     = ADDR_W + 1;
    localparam logic [WL_W-1:0]   DEPTH_WL = WL_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HI   = 3'd1,
        S_LO   = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t            state_q, state_d;

    logic [7:0]        hi_q, hi_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [WL_W-1:0]   words_q, words_d;

    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic              hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              xfer;
    logic              last_word;

    // A byte moves only when the registered ready and the source's valid coincide.
    assign xfer      = bus.in_valid & in_ready_q;
    // The word being written in WR is the one that fills the memory.
    assign last_word = (words_q + 1'b1) == DEPTH_WL;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured between loads.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (xfer) begin
                    state_d = bus.in_last ? S_ERR : S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (last_q) begin
                    state_d = S_DONE;
                end else if (last_word) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_HI;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: byte latching, word assembly, write pointer and word count.
    always_comb begin
        hi_d    = hi_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        words_d = words_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    addr_d  = '0;
                    words_d = '0;
                    last_d  = 1'b0;
                end
            end
            S_HI: begin
                if (xfer) begin
                    hi_d = bus.in_byte;
                end
            end
            S_LO: begin
                if (xfer) begin
                    wdata_d = {hi_q, bus.in_byte};
                    last_d  = bus.in_last;
                end
            end
            S_WR: begin
                // Pointer holds at the top word so it never wraps within a load.
                if (addr_q != ADDR_MAX) begin
                    addr_d = addr_q + 1'b1;
                end
                if (words_q != DEPTH_WL) begin
                    words_d = words_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output decode from the next state so every status output is a flop.
    always_comb begin
        in_ready_d = (state_d == S_HI) || (state_d == S_LO);
        we_d       = (state_d == S_WR);
        hold_d     = (state_d != S_DONE);
        busy_d     = (state_d == S_HI) || (state_d == S_LO) || (state_d == S_WR);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q       <= '0;
            last_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            words_q    <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            hold_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            hi_q       <= hi_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            words_q    <= words_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.imem_we      = we_q;
    assign bus.imem_addr    = addr_q;
    assign bus.imem_wdata   = wdata_q;
    assign bus.core_hold    = hold_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;
    assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader: table of program loads plus hand-written
// overflow, odd-length and reset-mid-load sequences, with a write scoreboard.
module tb_instr_mem_loader;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    typedef struct {
        int unsigned  n_bytes;
        logic [127:0] bytes;      // byte 0 in bits 127:120
        bit           with_last;
        bit           gaps;
        bit           exp_done;
        bit           exp_error;
        int unsigned  exp_words;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[7];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.imem_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: we=%b addr=0x%0h data=0x%0h, expected no write",
                         bus.imem_we, bus.imem_addr, bus.imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(bus.imem_addr), 32'(e.addr));
                check("write_data", 32'(bus.imem_wdata), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input bit gaps,
                             input bit push, input wr_t w, output bit ok);
        int t;
        if (gaps) begin
            int g;
            g = $urandom_range(0, 3);
            for (int k = 0; k < g; k++) begin
                bus.start = ($urandom_range(0, 2) == 0);
                tick();
            end
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        bus.in_last  = last;
        if (push) exp_q.push_back(w);
        ok = 1'b0;
        t  = 0;
        while (t < 50) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            t++;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready=%b for byte 0x%0h, expected 1 within 50 cycles",
                     bus.in_ready, b);
            bus.in_valid = 1'b0;
            return;
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (push) check("we_latency", 32'(bus.imem_we), 32'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        bit           ok;
        wr_t          w;
        logic [7:0]   b;
        logic [7:0]   prev;
        logic [127:0] bytes;
        int           t;
        bytes = v.bytes;
        prev  = 8'h00;
        pulse_start();
        check($sformatf("v%0d_start_busy", idx), 32'(bus.busy), 32'd1);
        check($sformatf("v%0d_start_hold", idx), 32'(bus.core_hold), 32'd1);
        check($sformatf("v%0d_start_done", idx), 32'(bus.done), 32'd0);
        check($sformatf("v%0d_start_error", idx), 32'(bus.error), 32'd0);
        check($sformatf("v%0d_start_words", idx), 32'(bus.words_loaded), 32'd0);
        for (int i = 0; i < int'(v.n_bytes); i++) begin
            b      = bytes[127 - 8*i -: 8];
            w.addr = ADDR_W'(i / 2);
            w.data = {prev, b};
            send_byte(b, v.with_last && (i == int'(v.n_bytes) - 1), v.gaps, (i % 2) == 1, w, ok);
            prev = b;
            if (!ok) break;
        end
        t = 0;
        while (bus.busy === 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("v%0d_end_busy", idx), 32'(bus.busy), 32'd0);
        check($sformatf("v%0d_end_done", idx), 32'(bus.done), 32'(v.exp_done));
        check($sformatf("v%0d_end_error", idx), 32'(bus.error), 32'(v.exp_error));
        check($sformatf("v%0d_end_hold", idx), 32'(bus.core_hold), 32'(!v.exp_done));
        check($sformatf("v%0d_end_ready", idx), 32'(bus.in_ready), 32'd0);
        check($sformatf("v%0d_end_words", idx), 32'(bus.words_loaded), 32'(v.exp_words));
        check($sformatf("v%0d_pending_writes", idx), 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_we"}, 32'(bus.imem_we), 32'd0);
        check({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(bus.imem_wdata), 32'd0);
        check({tag, "_hold"}, 32'(bus.core_hold), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_error"}, 32'(bus.error), 32'd0);
        check({tag, "_words"}, 32'(bus.words_loaded), 32'd0);
    endtask

    initial begin
        bit  ok;
        wr_t w;

        vecs[0] = '{n_bytes: 2,  bytes: {16'h1234, 112'h0}, with_last: 1, gaps: 0,
                    exp_done: 1, exp_error: 0, exp_words: 1};
        vecs[1] = '{n_bytes: 16, bytes: 128'h000102030405060708090A0B0C0D0E0F, with_last: 1, gaps: 0,
                    exp_done: 1, exp_error: 0, exp_words: 8};
        vecs[2] = '{n_bytes: 16, bytes: 128'h101112131415161718191A1B1C1D1E1F, with_last: 0, gaps: 0,
                    exp_done: 0, exp_error: 1, exp_words: 8};
        vecs[3] = '{n_bytes: 1,  bytes: {8'hAA, 120'h0}, with_last: 1, gaps: 0,
                    exp_done: 0, exp_error: 1, exp_words: 0};
        vecs[4] = '{n_bytes: 2,  bytes: {16'h5566, 112'h0}, with_last: 1, gaps: 0,
                    exp_done: 1, exp_error: 0, exp_words: 1};
        vecs[5] = '{n_bytes: 6,  bytes: {48'hDEADBEEFCAFE, 80'h0}, with_last: 1, gaps: 0,
                    exp_done: 1, exp_error: 0, exp_words: 3};
        vecs[6] = '{n_bytes: 16, bytes: 128'h000102030405060708090A0B0C0D0E0F, with_last: 1, gaps: 1,
                    exp_done: 1, exp_error: 0, exp_words: 8};

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        bus.in_last  = 1'b0;

        // Power-on reset values
        #12;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        check_reset_values("idle");

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
            if (i == 2) begin
                // After overflow the loader must refuse a 17th byte.
                bus.in_valid = 1'b1;
                bus.in_byte  = 8'h20;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("ovf_no_ready", 32'(bus.in_ready), 32'd0);
                    check("ovf_error_held", 32'(bus.error), 32'd1);
                end
                #1;
                bus.in_valid = 1'b0;
                tick();
            end
        end

        // Reset in the middle of a load: word 0 written, then reset while in LO.
        pulse_start();
        w.addr = '0;
        w.data = 16'h0000;
        send_byte(8'h12, 1'b0, 1'b0, 1'b0, w, ok);
        w.data = 16'h1234;
        send_byte(8'h34, 1'b0, 1'b0, 1'b1, w, ok);
        send_byte(8'h56, 1'b0, 1'b0, 1'b0, w, ok);
        check("midrst_busy_before", 32'(bus.busy), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h78;
        bus.in_last  = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("midrst");
        for (int k = 0; k < 3; k++) begin
            tick();
            check("midrst_hold_ready", 32'(bus.in_ready), 32'd0);
            check("midrst_hold_we", 32'(bus.imem_we), 32'd0);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("postrst_ready", 32'(bus.in_ready), 32'd0);
            check("postrst_busy", 32'(bus.busy), 32'd0);
            check("postrst_words", 32'(bus.words_loaded), 32'd0);
            check("postrst_hold", 32'(bus.core_hold), 32'd1);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        tick();
        check("final_pending_writes", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
